// File: rtl/multicycle_ctrl_if.sv
// Memory handshake between the multi-cycle sequencer (master) and the shared
// single-port memory (slave).
interface multicycle_ctrl_if;
  // mem_req is held, together with mem_we and iord, until the first cycle
  // where mem_ready=1. That cycle completes the transfer. mem_ready is
  // ignored while mem_req=0.
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output iord,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  iord,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB control, memory
// handshake, illegal-opcode and memory-timeout traps, retired-instruction count.
module multicycle_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [6:0]        opcode,
  multicycle_ctrl_if.master mem,
  output logic              ir_write,
  output logic              pc_write,
  output logic              pc_write_cond,
  output logic [1:0]        pc_src,
  output logic              alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [1:0]        aluop,
  output logic              reg_write,
  output logic [1:0]        wb_sel,
  output logic              retire,
  output logic [CNT_W-1:0]  retired_cnt,
  output logic              illegal,
  output logic              bus_err,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6,
    S_BAD    = 3'd7
  } state_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam int              WAIT_W     = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q;
  logic              mem_req_c, mem_we_c, iord_c;
  logic              done, set_ill, set_be;
  logic              mem_wait, timeout_hit;

  assign mem.mem_req = mem_req_c;
  assign mem.mem_we  = mem_we_c;
  assign mem.iord    = iord_c;
  assign state       = state_q;

  assign mem_wait    = mem_req_c && !mem.mem_ready;
  // mem_ready on the limit cycle still completes normally.
  assign timeout_hit = (TIMEOUT > 0) && (wait_q == WAIT_LIMIT) && !mem.mem_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    mem_req_c     = 1'b0;
    mem_we_c      = 1'b0;
    iord_c        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    aluop         = 2'b00;
    reg_write     = 1'b0;
    wb_sel        = 2'b00;
    retire        = 1'b0;
    done          = 1'b0;
    set_ill       = 1'b0;
    set_be        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req_c = 1'b1;
        alu_src_b = 2'b01;
        if (mem.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (timeout_hit) begin
          set_be  = 1'b1;
          state_d = S_TRAP;
        end
      end
      S_DECODE: begin
        // PC + imm computed here so branch/JAL targets sit in ALUOut for EXEC.
        alu_src_b = 2'b10;
        case (opcode)
          OP_R, OP_LD, OP_ST, OP_BR, OP_I, OP_JALR, OP_JAL: state_d = S_EXEC;
          default: begin
            set_ill = 1'b1;
            state_d = S_TRAP;
          end
        endcase
      end
      S_EXEC: begin
        case (opcode)
          OP_R: begin
            alu_src_a = 1'b1;
            aluop     = 2'b10;
            state_d   = S_WB;
          end
          OP_I: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            aluop     = 2'b10;
            state_d   = S_WB;
          end
          OP_LD, OP_ST: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = S_MEM;
          end
          OP_BR: begin
            alu_src_a     = 1'b1;
            aluop         = 2'b01;
            pc_write_cond = 1'b1;
            pc_src        = 2'b01;
            done          = 1'b1;
          end
          OP_JAL: begin
            pc_write  = 1'b1;
            pc_src    = 2'b01;
            reg_write = 1'b1;
            wb_sel    = 2'b10;
            done      = 1'b1;
          end
          OP_JALR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            aluop     = 2'b11;
            pc_write  = 1'b1;
            reg_write = 1'b1;
            wb_sel    = 2'b10;
            done      = 1'b1;
          end
          default: begin
            set_ill = 1'b1;
            state_d = S_TRAP;
          end
        endcase
      end
      S_MEM: begin
        mem_req_c = 1'b1;
        iord_c    = 1'b1;
        mem_we_c  = (opcode == OP_ST);
        if (mem.mem_ready) begin
          if (opcode == OP_ST) done = 1'b1;
          else                 state_d = S_WB;
        end else if (timeout_hit) begin
          set_be  = 1'b1;
          state_d = S_TRAP;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        wb_sel    = (opcode == OP_LD) ? 2'b01 : 2'b00;
        done      = 1'b1;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (done) begin
      retire  = 1'b1;
      state_d = run ? S_FETCH : S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_cnt <= '0;
      illegal     <= 1'b0;
      bus_err     <= 1'b0;
      wait_q      <= '0;
    end else begin
      if (retire)  retired_cnt <= retired_cnt + 1'b1;
      if (set_ill) illegal     <= 1'b1;
      if (set_be)  bus_err     <= 1'b1;
      // Any state change restarts the wait count, which covers entry to FETCH/MEM.
      if (state_d != state_q)
        wait_q <= '0;
      else if (mem_wait && wait_q != WAIT_LIMIT)
        wait_q <= wait_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: per-instruction expected control
// traces are built from the opcode class and memory wait counts, then replayed.
module tb_multicycle_ctrl;
  localparam int TO = 3;
  localparam int CW = 4;

  localparam int EV_NONE = 0;
  localparam int EV_RET  = 1;
  localparam int EV_ILL  = 2;
  localparam int EV_BE   = 3;
  localparam int EV_RST  = 4;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run = 1'b0;
  logic [6:0]    opcode = 7'd0;
  logic          ir_write, pc_write, pc_write_cond, alu_src_a, reg_write, retire;
  logic          illegal, bus_err;
  logic [1:0]    pc_src, alu_src_b, aluop, wb_sel;
  logic [CW-1:0] retired_cnt;
  logic [2:0]    dut_state;

  multicycle_ctrl_if mem_if ();

  multicycle_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .mem(mem_if),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .aluop(aluop),
    .reg_write(reg_write), .wb_sel(wb_sel), .retire(retire),
    .retired_cnt(retired_cnt), .illegal(illegal), .bus_err(bus_err), .state(dut_state)
  );

  always #5 clk = ~clk;

  logic [19:0] obs;
  assign obs = {dut_state, mem_if.mem_req, mem_if.mem_we, mem_if.iord, ir_write, pc_write,
                pc_write_cond, pc_src, alu_src_a, alu_src_b, aluop, reg_write, wb_sel, retire};

  // Scoreboard: one entry per expected cycle {state, control word}.
  logic [19:0] exp_q[$];
  int          rdy_q[$];
  int          run_q[$];
  bit          rst_q[$];
  int          ev_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int exp_cnt  = 0;
  bit exp_ill  = 0;
  bit exp_be   = 0;
  bit in_idle  = 1;
  logic [6:0] legal_ops [7] = '{OP_R, OP_LD, OP_ST, OP_BR, OP_I, OP_JALR, OP_JAL};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [16:0] mk(bit mreq, bit we, bit iord, bit irw, bit pcw, bit pcwc,
                                     logic [1:0] pcs, bit a, logic [1:0] b, logic [1:0] aop,
                                     bit rw, logic [1:0] wb, bit ret);
    return {mreq, we, iord, irw, pcw, pcwc, pcs, a, b, aop, rw, wb, ret};
  endfunction

  function automatic bit is_legal(logic [6:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  task automatic push(input logic [2:0] st, input logic [16:0] w, input int rdy, input int rn,
                      input bit rs, input int ev);
    exp_q.push_back({st, w});
    rdy_q.push_back(rdy);
    run_q.push_back(rn);
    rst_q.push_back(rs);
    ev_q.push_back(ev);
  endtask

  // n wait cycles then completion; more than TO waits ends in a bus-error trap.
  task automatic mem_phase(input logic [2:0] st, input logic [16:0] wait_w, input logic [16:0] done_w,
                           input int n, input int done_run, input int done_ev, output bit trapped);
    if (n > TO) begin
      for (int i = 0; i <= TO; i++) push(st, wait_w, 0, -1, 1'b0, (i == TO) ? EV_BE : EV_NONE);
      trapped = 1'b1;
    end else begin
      for (int i = 0; i < n; i++) push(st, wait_w, 0, -1, 1'b0, EV_NONE);
      push(st, done_w, 1, done_run, 1'b0, done_ev);
      trapped = 1'b0;
    end
  endtask

  task automatic drain(input logic [6:0] op);
    logic [19:0] e;
    int r, rn, ev;
    bit rs;
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      r  = rdy_q.pop_front();
      rn = run_q.pop_front();
      rs = rst_q.pop_front();
      ev = ev_q.pop_front();
      @(negedge clk);
      mem_if.mem_ready = (r < 0) ? 1'($urandom_range(0, 1)) : 1'(r);
      run    = (rn < 0) ? 1'($urandom_range(0, 1)) : 1'(rn);
      rst    = rs;
      opcode = (e[19:17] <= 3'd1) ? 7'($urandom_range(0, 127)) : op;
      #1;
      check("ctrl", 32'(obs), 32'(e));
      check("stat", 32'({retired_cnt, illegal, bus_err}), 32'({exp_cnt[CW-1:0], exp_ill, exp_be}));
      @(posedge clk);
      case (ev)
        EV_RET: begin exp_cnt = (exp_cnt + 1) % (1 << CW); in_idle = !run; end
        EV_ILL: exp_ill = 1'b1;
        EV_BE:  exp_be  = 1'b1;
        EV_RST: begin exp_cnt = 0; exp_ill = 1'b0; exp_be = 1'b0; in_idle = 1'b1; end
        default: ;
      endcase
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    run = 1'($urandom_range(0, 1));
    mem_if.mem_ready = 1'($urandom_range(0, 1));
    repeat (2) @(posedge clk);
    exp_cnt = 0; exp_ill = 1'b0; exp_be = 1'b0; in_idle = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run = 1'b0;
    #1;
    check("rst_ctrl", 32'(obs), 32'd0);
    check("rst_stat", 32'({retired_cnt, illegal, bus_err}), 32'd0);
    @(posedge clk);
  endtask

  task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input bit run_next,
                           input bit rst_in_mem);
    bit trapped;
    logic [16:0] w_ex_mem, w_ld, w_st;
    w_ex_mem = mk(0,0,0,0,0,0,2'b00,1,2'b10,2'b00,0,2'b00,0);
    w_ld     = mk(1,0,1,0,0,0,2'b00,0,2'b00,2'b00,0,2'b00,0);
    w_st     = mk(1,1,1,0,0,0,2'b00,0,2'b00,2'b00,0,2'b00,0);
    if (in_idle) push(3'd0, 17'd0, -1, 1, 1'b0, EV_NONE);
    mem_phase(3'd1, mk(1,0,0,0,0,0,2'b00,0,2'b01,2'b00,0,2'b00,0),
              mk(1,0,0,1,1,0,2'b00,0,2'b01,2'b00,0,2'b00,0), fw, -1, EV_NONE, trapped);
    if (!trapped) begin
      push(3'd2, mk(0,0,0,0,0,0,2'b00,0,2'b10,2'b00,0,2'b00,0), -1, -1, 1'b0,
           is_legal(op) ? EV_NONE : EV_ILL);
      trapped = !is_legal(op);
    end
    if (!trapped) begin
      case (op)
        OP_R: begin
          push(3'd3, mk(0,0,0,0,0,0,2'b00,1,2'b00,2'b10,0,2'b00,0), -1, -1, 1'b0, EV_NONE);
          push(3'd5, mk(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,1,2'b00,1), -1, run_next, 1'b0, EV_RET);
        end
        OP_I: begin
          push(3'd3, mk(0,0,0,0,0,0,2'b00,1,2'b10,2'b10,0,2'b00,0), -1, -1, 1'b0, EV_NONE);
          push(3'd5, mk(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,1,2'b00,1), -1, run_next, 1'b0, EV_RET);
        end
        OP_LD: begin
          push(3'd3, w_ex_mem, -1, -1, 1'b0, EV_NONE);
          mem_phase(3'd4, w_ld, w_ld, mw, -1, EV_NONE, trapped);
          if (!trapped)
            push(3'd5, mk(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,1,2'b01,1), -1, run_next, 1'b0, EV_RET);
        end
        OP_ST: begin
          push(3'd3, w_ex_mem, -1, -1, 1'b0, EV_NONE);
          if (rst_in_mem) push(3'd4, w_st, 0, -1, 1'b1, EV_RST);
          else mem_phase(3'd4, w_st, w_st | 17'd1, mw, run_next, EV_RET, trapped);
        end
        OP_BR:
          push(3'd3, mk(0,0,0,0,0,1,2'b01,1,2'b00,2'b01,0,2'b00,1), -1, run_next, 1'b0, EV_RET);
        OP_JAL:
          push(3'd3, mk(0,0,0,0,1,0,2'b01,0,2'b00,2'b00,1,2'b10,1), -1, run_next, 1'b0, EV_RET);
        default: // JALR
          push(3'd3, mk(0,0,0,0,1,0,2'b00,1,2'b10,2'b11,1,2'b10,1), -1, run_next, 1'b0, EV_RET);
      endcase
    end
    // A trap must hold with all controls low whatever run/mem_ready do.
    if (trapped) repeat (3) push(3'd6, 17'd0, -1, -1, 1'b0, EV_NONE);
    drain(op);
    if (trapped) do_reset();
  endtask

  initial begin
    int r, fw, mw;
    logic [6:0] op;
    mem_if.mem_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      #1;
      check("idle_ctrl", 32'(obs), 32'd0);
      check("idle_cnt", 32'(retired_cnt), 32'd0);
    end

    run_instr(OP_R,    0, 0, 1'b1, 1'b0);
    run_instr(OP_LD,   0, 2, 1'b1, 1'b0);
    run_instr(OP_ST,   1, 0, 1'b0, 1'b0);
    run_instr(OP_BR,   0, 0, 1'b1, 1'b0);
    run_instr(OP_JAL,  2, 0, 1'b1, 1'b0);
    run_instr(OP_JALR, 0, 0, 1'b0, 1'b0);
    run_instr(OP_I,    TO, 0, 1'b1, 1'b0);
    run_instr(OP_LD,   0, TO, 1'b0, 1'b0);
    run_instr(7'b1111111, 0, 0, 1'b1, 1'b0);
    run_instr(OP_R,    TO + 1, 0, 1'b1, 1'b0);
    run_instr(OP_ST,   0, TO + 1, 1'b1, 1'b0);
    run_instr(OP_ST,   0, 0, 1'b1, 1'b1);
    run_instr(OP_BR,   0, 0, 1'b1, 1'b0);

    for (int i = 0; i < (1 << CW) + 2; i++) run_instr(OP_BR, 0, 0, 1'b1, 1'b0);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) == 0) op = 7'($urandom_range(0, 127));
      else op = legal_ops[$urandom_range(0, 6)];
      r  = $urandom_range(0, 11);
      fw = (r == 11) ? TO + 1 : r % (TO + 1);
      r  = $urandom_range(0, 11);
      mw = (r == 11) ? TO + 1 : r % (TO + 1);
      run_instr(op, fw, mw, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
